mem_addr_seq: RTL
=================

# mem_addr_seq

Parametrised successor to the multicycle CPU's memory-address select. It picks one of `NUM_SRC` address sources (PC, ALU out, A, B, exception vector, ...) and registers the chosen address. It then holds that address stable for a configurable memory wait period and signals completion with a handshake. Invalid selects and misaligned word addresses are reported as error pulses and never produce an unknown address. It sits between the control unit and the memory address port.

## Interface
- `WIDTH`, 32: address width in bits.
- `NUM_SRC`, 5: number of address sources; must be between 2 and 2^`SEL_W`.
- `SEL_W`, 3: select width.
- `EXC_SRC`, 4: source index forced by `exc_force`; must be less than `NUM_SRC`.
- `WAIT_CYCLES`, 1: memory latency in cycles; must be at least 1.
- `ALIGN_CHK`, 1: if 1, word accesses with `addr[1:0]`≠0 are rejected.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `src_bus`  in  `NUM_SRC*WIDTH`  packed sources; source i is `src_bus[i*WIDTH +: WIDTH]`.
- `sel`  in  `SEL_W`  source index.
- `start`  in  1  access request, sampled in IDLE and DONE.
- `word`  in  1  1 = word access, which is subject to the alignment check; 0 = byte access.
- `exc_force`  in  1  on an accepted start, overrides `sel` with `EXC_SRC` and bypasses the alignment check.
- `addr`  out  `WIDTH`  registered memory address.
- `busy`  out  1  high in WAIT and DONE.
- `done`  out  1  high for exactly one cycle, in DONE.
- `err_sel`  out  1  one-cycle pulse: `sel` ≥ `NUM_SRC` on a start.
- `err_align`  out  1  one-cycle pulse: misaligned word start.

## Operation
- States: IDLE, WAIT, DONE. Internal down-counter `cnt` is `$clog2(WAIT_CYCLES+1)` bits wide.
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, cnt=0;
  - `addr`=0;
  - `busy`, `done`, `err_sel`, `err_align` all 0.
- Effective index: `eidx` = `exc_force` ? `EXC_SRC` : `sel`. The candidate address is source `eidx`.
- Start in IDLE, checks in priority order:
  1. `exc_force`=0 and `sel` ≥ `NUM_SRC` → `err_sel`=1 for one cycle; stay in IDLE; `addr` unchanged.
  2. Otherwise, `ALIGN_CHK`=1, `word`=1, `exc_force`=0 and candidate[1:0]≠0 → `err_align`=1 for one cycle; stay in IDLE; `addr` unchanged.
  3. Otherwise → `addr` ← candidate; `cnt` ← `WAIT_CYCLES`; state ← WAIT.
- WAIT:
  - each edge: `cnt` ← `cnt`−1;
  - at the edge where `cnt`=1: state ← DONE;
  - `start`, `sel` and `exc_force` are ignored;
  - `addr` is held constant.
- DONE:
  - `done`=1 for this one cycle;
  - next edge: if `start` is present, it is evaluated exactly as in IDLE (back-to-back access, errors return to IDLE); else state ← IDLE.
- IDLE with no start: `addr` holds its last value; all flags are 0.
- `exc_force` outside an accepted start has no effect.
- The error flags are never both set on the same cycle.

## Timing
- For a start accepted at edge k:
  - `addr` is valid after edge k;
  - `busy` is 1 from k through k+`WAIT_CYCLES`;
  - `done` is 1 in the cycle after edge k+`WAIT_CYCLES`;
  - state returns to IDLE at edge k+`WAIT_CYCLES`+1.
- Throughput: one access per `WAIT_CYCLES`+1 cycles when `start` is held.
- Error pulses appear in the cycle after the sampling edge and last exactly one cycle.
- Reset asserted mid-access: all outputs clear immediately (asynchronously). The first start after release is accepted at the first rising edge with reset=1.
- No combinational path from any input to any output.

## Test plan
1. Reset, then start with sel=1, src1=0x0000_0040, WAIT_CYCLES=1 → `addr`=0x40 after edge k; `busy` high for 2 cycles; `done` high in cycle k+2 only; back to IDLE.
2. `start` held high, sel=0 then sel=2, src0=0x100, src2=0x200 → `addr` changes to 0x200 at the DONE→WAIT edge with no IDLE cycle; `done` pulses every 2 cycles.
3. sel=5 with `NUM_SRC`=5 → `err_sel` pulses for one cycle; `addr` keeps its prior value; `busy` stays 0. Repeat with `exc_force`=1 → accepted, `addr`=src4.
4. word=1, sel=1, src1=0x0000_0042 → `err_align` pulses, no access. Same value with word=0 → accepted, `addr`=0x42.
5. Assert reset during WAIT with WAIT_CYCLES=3 → `addr`, `busy` and `done` are all 0 before the next edge. After release, start sel=0 → normal 4-cycle access.
6. Start accepted; during WAIT drive sel=3 and pulse `start`/`exc_force` → `addr` unchanged, no second access, and `done` occurs on schedule.

Source files
------------

// File: rtl/mem_addr_seq.sv
// mem_addr_seq
//
// Memory-address sequencer for the multicycle CPU. It selects one of NUM_SRC
// address sources, registers the chosen address, and holds it stable for
// WAIT_CYCLES memory-latency cycles. It then raises a one-cycle done strobe.
// An out-of-range select or a misaligned word address is rejected with a
// one-cycle error pulse. A rejected request leaves the address unchanged, so
// the address never becomes unknown.
//
// Parameters
//   WIDTH       address width
//   NUM_SRC     number of address sources (2 .. 2**SEL_W)
//   SEL_W       select width
//   EXC_SRC     source forced by exc_force (< NUM_SRC)
//   WAIT_CYCLES memory latency in cycles (>= 1)
//   ALIGN_CHK   1 = word accesses must be 4-byte aligned
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   src_bus    in   packed sources, source i at src_bus[i*WIDTH +: WIDTH]
//   sel        in   source index
//   start      in   access request (sampled in IDLE and DONE)
//   word       in   1 = word access (alignment checked), 0 = byte access
//   exc_force  in   on an accepted start, use EXC_SRC and skip alignment check
//   addr       out  registered memory address
//   busy       out  high while an access is in WAIT or DONE
//   done       out  one-cycle completion strobe
//   err_sel    out  one-cycle pulse: start with sel >= NUM_SRC
//   err_align  out  one-cycle pulse: start with misaligned word address
module mem_addr_seq #(
    parameter int WIDTH       = 32,
    parameter int NUM_SRC     = 5,
    parameter int SEL_W       = 3,
    parameter int EXC_SRC     = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int ALIGN_CHK   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    input  logic                     word,
    input  logic                     exc_force,
    output logic [WIDTH-1:0]         addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err_sel,
    output logic                     err_align
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   addr_nxt;
    logic               err_sel_nxt, err_align_nxt;

    logic [SEL_W-1:0]   eidx;
    logic [WIDTH-1:0]   cand;
    logic               sel_bad, align_bad;

    assign eidx = exc_force ? SEL_W'(EXC_SRC) : sel;

    // The extra select bit keeps the range check meaningful when NUM_SRC
    // equals 2**SEL_W. In that case every select value is legal.
    assign sel_bad = !exc_force && ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));

    // An unmatched index yields zero instead of an out-of-range part-select.
    // Such a candidate is never committed, because sel_bad takes priority.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eidx == SEL_W'(i)) begin
                cand = src_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    assign align_bad = (ALIGN_CHK != 0) && word && !exc_force &&
                       (cand[1:0] != 2'b00);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        addr_nxt      = addr;
        err_sel_nxt   = 1'b0;
        err_align_nxt = 1'b0;
        case (state)
            // DONE handles start exactly like IDLE. This permits back-to-back
            // accesses with no idle cycle between them.
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    if (sel_bad) begin
                        err_sel_nxt = 1'b1;
                    end else if (align_bad) begin
                        err_align_nxt = 1'b1;
                    end else begin
                        addr_nxt  = cand;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr      <= '0;
            err_sel   <= 1'b0;
            err_align <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr      <= addr_nxt;
            err_sel   <= err_sel_nxt;
            err_align <= err_align_nxt;
        end
    end

    // Both strobes decode the state register, so no input reaches an output
    // through combinational logic.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
